xc_sha3_dec: RTL and testbench

XC_SHA3_DEC -- requirements
Module: xc_sha3_dec

---
 rtl/xc_sha3_pkg.sv | 33 +++
 rtl/xc_sha3_div5.sv | 54 +++++
 rtl/xc_sha3_dec.sv | 141 ++++++++++++++
 tb/tb_xc_sha3_dec.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/xc_sha3_pkg.sv
// Shared constants and encodings for the SHA-3 lane-offset decoder.
package xc_sha3_pkg;

  localparam int COORD_W = 5;
  localparam logic [31:0] LANE_COUNT = 32'd25;
  localparam logic [COORD_W-1:0] LANE_MOD = 5'd5;
  localparam logic [31:0] ERR_RESULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    FN_XY = 3'd0,
    FN_X1 = 3'd1,
    FN_X2 = 3'd2,
    FN_X4 = 3'd3,
    FN_YX = 3'd4
  } fn_e;

  // Reduces any 5-bit value modulo 5.
  function automatic logic [COORD_W-1:0] mod5(input logic [COORD_W-1:0] v);
    logic [COORD_W-1:0] t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      if (t >= LANE_MOD) t = t - LANE_MOD;
    end
    return t;
  endfunction

endpackage

// File: rtl/xc_sha3_div5.sv
// Iterative divide-by-5: one subtraction per cycle until the remainder drops below 5.
module xc_sha3_div5
  import xc_sha3_pkg::*;
(
  input  logic               g_clk,
  input  logic               g_rst,
  input  logic               start,
  input  logic [COORD_W-1:0] dividend,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] quotient,
  output logic [COORD_W-1:0] remainder
);

  logic               busy_q, busy_d;
  logic [COORD_W-1:0] quo_q, quo_d;
  logic [COORD_W-1:0] rem_q, rem_d;

  always_comb begin
    busy_d = busy_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    if (start) begin
      busy_d = 1'b1;
      quo_d  = '0;
      rem_d  = dividend;
    end else if (busy_q) begin
      if (rem_q >= LANE_MOD) begin
        rem_d = rem_q - LANE_MOD;
        quo_d = quo_q + 5'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      busy_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (rem_q < LANE_MOD);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/xc_sha3_dec.sv
// Decodes an encoded Keccak lane offset into (x, y) coordinates with one of five inverse maps.
// Define XC_SHA3_DEC_YX_EN to enable the f_yx inverse; otherwise f_yx is rejected as an error.
module xc_sha3_dec
  import xc_sha3_pkg::*;
#(
  parameter int Y_LSB = 8
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [1:0]  shamt,
  input  logic        f_xy,
  input  logic        f_x1,
  input  logic        f_x2,
  input  logic        f_x4,
  input  logic        f_yx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  fn_e         fsel_q, fsel_d;
  logic [31:0] result_q, result_d;

  logic [4:0]  sel_vec;
  logic        sel_ok, misalign, range_err, req_err;
  logic [31:0] idx, mask;
  fn_e         fn_in;

  logic               div_start, div_busy, div_done;
  logic [COORD_W-1:0] div_q, div_r, x_val, y_val;
  logic [31:0]        good_res;

  always_comb begin
    sel_vec   = {f_yx, f_x4, f_x2, f_x1, f_xy};
    mask      = (32'd1 << shamt) - 32'd1;
    misalign  = |(rs1 & mask);
    idx       = rs1 >> shamt;
    range_err = (idx >= LANE_COUNT);
    sel_ok    = $onehot(sel_vec);
`ifndef XC_SHA3_DEC_YX_EN
    sel_ok    = sel_ok & ~f_yx;
`endif
    req_err   = misalign | range_err | ~sel_ok;
    fn_in     = FN_XY;
    if (f_x1) fn_in = FN_X1;
    if (f_x2) fn_in = FN_X2;
    if (f_x4) fn_in = FN_X4;
`ifdef XC_SHA3_DEC_YX_EN
    if (f_yx) fn_in = FN_YX;
`endif
  end

  xc_sha3_div5 u_div5 (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .start     (div_start),
    .dividend  (idx[COORD_W-1:0]),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Offsets are subtracted as +5-k so the intermediate never goes negative.
  always_comb begin
    x_val = div_r;
    y_val = div_q;
    case (fsel_q)
      FN_X1: x_val = mod5(div_r + LANE_MOD - 5'd1);
      FN_X2: x_val = mod5(div_r + LANE_MOD - 5'd2);
      FN_X4: x_val = mod5(div_r + LANE_MOD - 5'd4);
`ifdef XC_SHA3_DEC_YX_EN
      FN_YX: begin
        x_val = mod5(div_q + div_q + div_q + div_r);
        y_val = div_r;
      end
`endif
      default: begin
        x_val = div_r;
        y_val = div_q;
      end
    endcase
    good_res                     = '0;
    good_res[COORD_W-1:0]        = x_val;
    good_res[Y_LSB +: COORD_W]   = y_val;
  end

  always_comb begin
    state_d   = state_q;
    fsel_d    = fsel_q;
    result_d  = result_q;
    div_start = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~div_busy;
        if (in_valid && in_ready) begin
          if (req_err) begin
            state_d  = DONE;
            result_d = ERR_RESULT;
          end else begin
            state_d   = DIV;
            fsel_d    = fn_in;
            div_start = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          state_d  = DONE;
          result_d = good_res;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= IDLE;
      fsel_q   <= FN_XY;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fsel_q   <= fsel_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_xc_sha3_dec.sv
// Self-checking bench for xc_sha3_dec: arithmetic reference model plus directed literal vectors.
module tb_xc_sha3_dec;

  localparam int YL = 8;
`ifdef XC_SHA3_DEC_YX_EN
  localparam bit YX = 1'b1;
`else
  localparam bit YX = 1'b0;
`endif

  logic        g_clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] rs1 = '0;
  logic [1:0]  shamt = '0;
  logic        f_xy = 1'b0, f_x1 = 1'b0, f_x2 = 1'b0, f_x4 = 1'b0, f_yx = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  xc_sha3_dec #(.Y_LSB(YL)) dut (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .shamt     (shamt),
    .f_xy      (f_xy),
    .f_x1      (f_x1),
    .f_x2      (f_x2),
    .f_x4      (f_x4),
    .f_yx      (f_yx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference: decode straight from the arithmetic definition.
  function automatic void model(input logic [31:0] a, input logic [1:0] s, input logic [4:0] sel,
                                output logic [31:0] res, output int lat);
    longint unsigned p, idx, q, r, x, y;
    bit err;
    p   = 64'd1 << s;
    idx = longint'(a) / p;
    err = ((longint'(a) % p) != 0) || (idx >= 25) || ($countones(sel) != 1) || (sel[4] && !YX);
    if (err) begin
      res = 32'h8000_0000;
      lat = 1;
    end else begin
      q = idx / 5;
      r = idx % 5;
      y = q;
      if (sel[0])      x = r;
      else if (sel[1]) x = (r + 4) % 5;
      else if (sel[2]) x = (r + 3) % 5;
      else if (sel[3]) x = (r + 1) % 5;
      else begin
        x = (3 * q + r) % 5;
        y = r;
      end
      res = 32'(x) | (32'(y) << YL);
      lat = int'(q) + 2;
    end
  endfunction

  // Compare process: tracks the one outstanding request and checks every cycle.
  logic        exp_active = 1'b0;
  int          exp_due = 0;
  logic [31:0] exp_res = '0;

  initial begin
    logic [31:0] mres;
    int          mlat;
    forever begin
      @(negedge g_clk);
      if (g_rst) begin
        exp_active = 1'b0;
      end else if (!exp_active) begin
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        if (in_valid) begin
          model(rs1, shamt, {f_yx, f_x4, f_x2, f_x1, f_xy}, mres, mlat);
          exp_active = 1'b1;
          exp_due    = cyc + mlat;
          exp_res    = mres;
        end
      end else if (cyc < exp_due) begin
        chk("busy_out_valid", 32'(out_valid), 32'd0);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
      end else begin
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_result", result, exp_res);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        if (out_ready) exp_active = 1'b0;
      end
    end
  end

  task automatic drive_sel(input logic [4:0] sel);
    {f_yx, f_x4, f_x2, f_x1, f_xy} = sel;
  endtask

  task automatic run(input string nm, input logic [31:0] a, input logic [1:0] s, input logic [4:0] sel,
                     input int hold, input logic [31:0] want, input int want_lat);
    int acc;
    bit seen;
    seen = 1'b0;
    @(posedge g_clk); #1;
    rs1 = a; shamt = s; drive_sel(sel); in_valid = 1'b1;
    acc = cyc;
    @(posedge g_clk); #1;
    // Garbage while busy must be ignored.
    rs1 = $urandom; shamt = 2'($urandom); drive_sel(5'($urandom));
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge g_clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_latency"}, 32'(cyc - acc), 32'(want_lat));
      chk({nm, "_result"}, result, want);
    end
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge g_clk);
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_result"}, result, want);
      chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge g_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge g_clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] pres;
    int          plat;

    // Pin the model with hand-computed values.
    model(32'h38, 2'd2, 5'b00001, pres, plat);
    chk("pin_xy_res", pres, 32'h0000_0204);
    chk("pin_xy_lat", 32'(plat), 32'd4);
    model(32'h0, 2'd0, 5'b00010, pres, plat);
    chk("pin_x1_res", pres, 32'h0000_0004);
    model(32'h65, 2'd2, 5'b00001, pres, plat);
    chk("pin_misalign", pres, 32'h8000_0000);
    model(32'hC0, 2'd3, 5'b01000, pres, plat);
    chk("pin_x4_res", pres, 32'h0000_0400);

    repeat (3) @(posedge g_clk);
    #1 g_rst = 1'b0;
    @(negedge g_clk);
    chk("rst_result", result, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run("xy14",     32'h38, 2'd2, 5'b00001, 0, 32'h0000_0204, 4);
    run("x1_0",     32'h00, 2'd0, 5'b00010, 0, 32'h0000_0004, 2);
    if (YX) begin
      run("yx7",    32'h07, 2'd0, 5'b10000, 0, 32'h0000_0200, 3);
      run("yx13",   32'h0D, 2'd0, 5'b10000, 0, 32'h0000_0304, 4);
    end else begin
      run("yx7",    32'h07, 2'd0, 5'b10000, 0, 32'h8000_0000, 1);
      run("yx13",   32'h0D, 2'd0, 5'b10000, 0, 32'h8000_0000, 1);
    end
    run("misalign", 32'h65, 2'd2, 5'b00001, 0, 32'h8000_0000, 1);
    run("range25",  32'd25, 2'd0, 5'b00001, 0, 32'h8000_0000, 1);
    run("two_sel",  32'd3,  2'd0, 5'b00110, 0, 32'h8000_0000, 1);
    run("no_sel",   32'd3,  2'd0, 5'b00000, 0, 32'h8000_0000, 1);
    run("x4_24",    32'hC0, 2'd3, 5'b01000, 0, 32'h0000_0400, 6);
    run("x2_11",    32'd11, 2'd0, 5'b00100, 0, 32'h0000_0204, 4);
    run("hold5",    32'h38, 2'd2, 5'b00001, 5, 32'h0000_0204, 4);
    run("err_hold", 32'd30, 2'd0, 5'b00010, 3, 32'h8000_0000, 1);

    // Reset in the middle of dividing 24.
    @(posedge g_clk); #1;
    rs1 = 32'd24; shamt = 2'd0; drive_sel(5'b00001); in_valid = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    @(posedge g_clk); #1;
    g_rst = 1'b1;
    @(posedge g_clk); #1;
    g_rst = 1'b0;
    @(negedge g_clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end

    run("after_rst", 32'd24, 2'd0, 5'b00001, 0, 32'h0000_0404, 6);

    repeat (2) @(posedge g_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
